// File: rtl/link_tx_arbiter_if.sv
// Bundle between the three packet sources, the arbiter and the internode link TX word.
interface link_tx_arbiter_if #(
  parameter int DataWidth = 256
);
  logic [DataWidth-1:0] req_data_0, req_data_1, req_data_2;
  logic                 req_valid_0, req_valid_1, req_valid_2;
  logic                 req_ack_0, req_ack_1, req_ack_2;
  logic                 tx_ready;
  logic [DataWidth-1:0] tx_data;
  logic                 tx_valid;
  logic [7:0]           util_0, util_1, util_2;

  modport slave (
    input  req_data_0, req_data_1, req_data_2,
    input  req_valid_0, req_valid_1, req_valid_2,
    output req_ack_0, req_ack_1, req_ack_2,
    input  tx_ready,
    output tx_data, tx_valid,
    output util_0, util_1, util_2
  );

  modport master (
    output req_data_0, req_data_1, req_data_2,
    output req_valid_0, req_valid_1, req_valid_2,
    input  req_ack_0, req_ack_1, req_ack_2,
    output tx_ready,
    input  tx_data, tx_valid,
    input  util_0, util_1, util_2
  );
endinterface

// File: rtl/link_tx_arbiter.sv
// Three-way link TX arbiter: starvation first, then priority, round-robin ties; grant to tx_valid 1 cycle.
// Held word stalls while !tx_ready; acks only when the output slot frees. Also counts per-source utilisation.
module link_tx_arbiter #(
  parameter int DataWidth     = 256,
  parameter int PriorityPos   = 152,
  parameter int PriorityWidth = 8,
  parameter int StarveWidth   = 6,
  parameter int StarveLimit   = 32
) (
  input  logic             clk,
  input  logic             rst,
  link_tx_arbiter_if.slave bus
);
  localparam int NumSrc = 3;

  logic [NumSrc-1:0]        req_valid, req_ack;
  logic [DataWidth-1:0]     req_data [NumSrc];
  logic [StarveWidth-1:0]   wait_cnt [NumSrc];
  logic [7:0]               gcnt     [NumSrc];
  logic [7:0]               util     [NumSrc];
  logic [8:0]               util_sum [NumSrc];
  logic [7:0]               win_cnt;
  logic [1:0]               rr_ptr, gnt_idx;
  logic [NumSrc-1:0]        starving, prio_match, cand;
  logic [PriorityWidth-1:0] max_prio;
  logic [DataWidth-1:0]     tx_data, gnt_data;
  logic                     tx_valid, slot_free, grant_en, found;

  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int k);
    int s = int'(base) + k;
    return 2'(s % NumSrc);
  endfunction

  assign req_valid   = {bus.req_valid_2, bus.req_valid_1, bus.req_valid_0};
  assign req_data[0] = bus.req_data_0;
  assign req_data[1] = bus.req_data_1;
  assign req_data[2] = bus.req_data_2;

  assign slot_free = !tx_valid || bus.tx_ready;
  assign grant_en  = slot_free && (|req_valid);

  always_comb begin
    max_prio   = '0;
    starving   = '0;
    prio_match = '0;
    cand       = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    req_ack    = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (req_valid[i] && req_data[i][PriorityPos +: PriorityWidth] > max_prio)
        max_prio = req_data[i][PriorityPos +: PriorityWidth];
    end
    for (int i = 0; i < NumSrc; i++) begin
      starving[i]   = req_valid[i] && (wait_cnt[i] >= StarveWidth'(StarveLimit));
      prio_match[i] = req_valid[i] && (req_data[i][PriorityPos +: PriorityWidth] == max_prio);
    end
    // Starving sources bypass priority entirely; RR then resolves among the survivors.
    cand = (|starving) ? starving : prio_match;
    for (int k = 1; k <= NumSrc; k++) begin
      if (!found && cand[wrap_idx(rr_ptr, k)]) begin
        found   = 1'b1;
        gnt_idx = wrap_idx(rr_ptr, k);
      end
    end
    if (grant_en && rst)
      req_ack[gnt_idx] = 1'b1;
  end

  always_comb begin
    case (gnt_idx)
      2'd1:    gnt_data = req_data[1];
      2'd2:    gnt_data = req_data[2];
      default: gnt_data = req_data[0];
    endcase
    for (int i = 0; i < NumSrc; i++)
      util_sum[i] = {1'b0, gcnt[i]} + {8'b0, req_ack[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rr_ptr   <= '0;
    end else if (slot_free) begin
      if (grant_en) begin
        tx_data                <= gnt_data;
        tx_data[DataWidth-1]   <= 1'b1;
        tx_valid               <= 1'b1;
        rr_ptr                 <= gnt_idx;
      end else begin
        tx_valid               <= 1'b0;
        tx_data[DataWidth-1]   <= 1'b0;
      end
    end
  end

  // Waits keep aging through link stalls so a stalled link cannot hide starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumSrc; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumSrc; i++) begin
        if (!req_valid[i] || req_ack[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != '1)
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      for (int i = 0; i < NumSrc; i++) begin
        gcnt[i] <= '0;
        util[i] <= '0;
      end
    end else begin
      win_cnt <= win_cnt + 1'b1;
      for (int i = 0; i < NumSrc; i++) begin
        if (win_cnt == 8'hFF) begin
          util[i] <= util_sum[i][8] ? 8'hFF : util_sum[i][7:0];
          gcnt[i] <= '0;
        end else if (req_ack[i] && gcnt[i] != 8'hFF) begin
          gcnt[i] <= gcnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.req_ack_0 = req_ack[0];
  assign bus.req_ack_1 = req_ack[1];
  assign bus.req_ack_2 = req_ack[2];
  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;
  assign bus.util_0    = util[0];
  assign bus.util_1    = util[1];
  assign bus.util_2    = util[2];
endmodule

// File: tb/tb_link_tx_arbiter.sv
// Directed bench for link_tx_arbiter: reset, priority, round-robin, backpressure, starvation, utilisation.
module tb_link_tx_arbiter;
  logic clk;
  logic rst;

  link_tx_arbiter_if #(.DataWidth(256)) bus ();

  link_tx_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         compared   = 0;
  int         mismatched = 0;
  logic       vld [3];
  logic [7:0] pr  [3];
  int         seq [3];
  logic       rdy;

  function automatic logic [255:0] mk(input int src, input logic [7:0] p, input int sq);
    logic [255:0] d = '0;
    d[152 +: 8] = p;
    d[15:0]     = 16'(sq);
    d[23:16]    = 8'(src);
    d[200 +: 8] = 8'hA5;
    return d;
  endfunction

  function automatic logic [255:0] txw(input logic [255:0] d);
    logic [255:0] r = d;
    r[255] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_data_0  = mk(0, pr[0], seq[0]);
    bus.req_data_1  = mk(1, pr[1], seq[1]);
    bus.req_data_2  = mk(2, pr[2], seq[2]);
    bus.req_valid_0 = vld[0];
    bus.req_valid_1 = vld[1];
    bus.req_valid_2 = vld[2];
    bus.tx_ready    = rdy;
  endtask

  // One cycle: check acks and TX word mid-cycle, then let acked sources pop.
  task automatic cyc(input string tag, input logic [2:0] eack, input logic etv, input logic [255:0] etd);
    @(negedge clk);
    chk({tag, ".ack"}, 256'({bus.req_ack_2, bus.req_ack_1, bus.req_ack_0}), 256'(eack));
    chk({tag, ".vld"}, 256'(bus.tx_valid), 256'(etv));
    if (etv) chk({tag, ".dat"}, bus.tx_data, etd);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if (eack[i]) seq[i]++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      pr[i]  = 8'h00;
      seq[i] = 0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [255:0] last_d, cur_d;
    int           s;

    // Reset / idle
    do_reset();
    rst = 1'b0;
    vld[0] = 1'b1;
    drive();
    #1;
    chk("rst.ack", 256'({bus.req_ack_2, bus.req_ack_1, bus.req_ack_0}), 256'(3'b000));
    chk("rst.txv", 256'(bus.tx_valid), 256'(1'b0));
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle.ack", 256'({bus.req_ack_2, bus.req_ack_1, bus.req_ack_0}), 256'(3'b000));
      chk("idle.txv", 256'(bus.tx_valid), 256'(1'b0));
      chk("idle.txd", bus.tx_data, 256'(0));
      chk("idle.util", 256'({bus.util_2, bus.util_1, bus.util_0}), 256'(0));
    end
    @(posedge clk); #1;

    // Priority: 0x10 / 0x80 / 0x40 -> order 1, 2, 0
    do_reset();
    pr[0] = 8'h10; pr[1] = 8'h80; pr[2] = 8'h40;
    vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
    drive();
    cyc("pri0", 3'b010, 1'b0, '0);
    vld[1] = 1'b0; drive();
    cyc("pri1", 3'b100, 1'b1, txw(mk(1, 8'h80, 0)));
    vld[2] = 1'b0; drive();
    cyc("pri2", 3'b001, 1'b1, txw(mk(2, 8'h40, 0)));
    vld[0] = 1'b0; drive();
    cyc("pri3", 3'b000, 1'b1, txw(mk(0, 8'h10, 0)));
    cyc("pri4", 3'b000, 1'b0, '0);

    // Round-robin at equal priority from rr_ptr=0: 1,2,0,1,2,0
    do_reset();
    pr[0] = 8'h20; pr[1] = 8'h20; pr[2] = 8'h20;
    vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
    drive();
    last_d = '0;
    for (int k = 0; k < 6; k++) begin
      s     = (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 2 : 0);
      cur_d = txw(mk(s, 8'h20, seq[s]));
      cyc("rr", 3'(1 << s), (k != 0), last_d);
      last_d = cur_d;
    end

    // Backpressure: held word stable, no acks, grant again on the release cycle
    do_reset();
    pr[0] = 8'h20; vld[0] = 1'b1;
    drive();
    cyc("bp.g0", 3'b001, 1'b0, '0);
    rdy = 1'b0; drive();
    for (int c = 0; c < 5; c++) cyc("bp.stall", 3'b000, 1'b1, txw(mk(0, 8'h20, 0)));
    rdy = 1'b1; drive();
    cyc("bp.rel", 3'b001, 1'b1, txw(mk(0, 8'h20, 0)));
    cyc("bp.next", 3'b001, 1'b1, txw(mk(0, 8'h20, 1)));
    vld[0] = 1'b0; drive();
    cyc("bp.last", 3'b000, 1'b1, txw(mk(0, 8'h20, 2)));
    cyc("bp.idle", 3'b000, 1'b0, '0);

    // Starvation: source 2 forced after 32 waits, i.e. every 33rd cycle
    do_reset();
    pr[0] = 8'hFF; pr[2] = 8'h01;
    vld[0] = 1'b1; vld[2] = 1'b1;
    drive();
    last_d = '0;
    for (int c = 0; c < 66; c++) begin
      s     = (c % 33 == 32) ? 2 : 0;
      cur_d = txw(mk(s, pr[s], seq[s]));
      cyc("starve", 3'(1 << s), (c != 0), last_d);
      last_d = cur_d;
    end

    // Utilisation: continuous (saturates at 255) then alternate cycles (128)
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      for (int i = 0; i < 512; i++) begin
        vld[0] = (mode == 0) ? 1'b1 : (i % 2 == 0);
        drive();
        @(posedge clk); #1;
        if (i == 254) chk("util.pre", 256'(bus.util_0), 256'(0));
        if (i == 255) chk("util.win1", 256'(bus.util_0), (mode == 0) ? 256'(255) : 256'(128));
      end
      chk("util.win2", 256'(bus.util_0), (mode == 0) ? 256'(255) : 256'(128));
      chk("util.other", 256'({bus.util_2, bus.util_1}), 256'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/link_tx_arbiter.md
Name: link_tx_arbiter

Overview:
- Shares one outbound internode link between three packet sources:
  - clockwise transit traffic (req 0)
  - counter-clockwise transit traffic (req 1)
  - local injection (req 2)
- Sits between the switch output stage and internode_link, and drives the link's parallel TX word.
- Arbitration uses the packet priority field with round-robin tie-break and starvation override.
- Also produces the per-source 8-bit link utilisation figures that the node exports.

Parameters:
DataWidth, 256, packet width; bit DataWidth-1 of tx_data carries the valid flag.
PriorityPos, 152, LSB position of the priority field in a packet.
PriorityWidth, 8, priority field width; a larger value means more urgent.
StarveWidth, 6, width of the per-source wait counter.
StarveLimit, 32, wait cycles after which a source is forced; must be ≤ 2^StarveWidth-1.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-low reset.
req_data_0/1/2  input  DataWidth  packet offered by source 0/1/2.
req_valid_0/1/2  input  1  source 0/1/2 is offering a packet.
req_ack_0/1/2  output  1  source packet consumed this cycle; the source pops it.
tx_ready  input  1  link can take a word (EjectSlotAvail).
tx_data  output  DataWidth  registered word to the link; bit DataWidth-1 equals tx_valid.
tx_valid  output  1  tx_data holds a packet.
util_0/1/2  output  8  grants to source 0/1/2 in the last completed 256-cycle window.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_valid=0, tx_data=0, util_*=0.
  - Wait counters=0, RR pointer=0, window counter=0, grant counters=0.
  - req_ack_* are combinational and read 0 while in reset.
  - Reset mid-transfer drops the held word; it is not replayed.
- Output register:
  - slot_free = !tx_valid || tx_ready.
  - A word is accepted by the link on any cycle with tx_valid && tx_ready.
  - tx_data and tx_valid hold unchanged while tx_valid && !tx_ready.
- Grant:
  - Computed combinationally only when slot_free and at least one req_valid is set.
  - Exactly one req_ack_i is asserted in a grant cycle. It is never asserted when !slot_free or !req_valid_i.
  - On the next edge: tx_data <= req_data_i with bit DataWidth-1 forced to 1, and tx_valid <= 1.
  - If slot_free and no source is valid: tx_valid <= 0 and tx_data bit DataWidth-1 <= 0.
  - Latency is 1 cycle from grant to tx_valid. Back-to-back grants every cycle are allowed while tx_ready=1.
- Selection order:
  1. Starving sources: wait_i ≥ StarveLimit. If several are starving, pick round-robin among them.
  2. Otherwise, the highest req_data_i[PriorityPos+:PriorityWidth] among valid sources.
  3. Priority ties are broken round-robin.
- Round-robin:
  - The search starts at the index after rr_ptr and wraps 2→0.
  - rr_ptr <= granted index on every grant. It is unchanged when there is no grant.
- Wait counters:
  - wait_i <= 0 when !req_valid_i or req_ack_i.
  - Otherwise wait_i increments, saturating at 2^StarveWidth-1.
  - Counters increment even while tx_ready=0, so stalls age all sources.
- Utilisation:
  - win_cnt is 8 bits and increments every cycle, wrapping 255→0.
  - gcnt_i increments on each req_ack_i, saturating at 255.
  - On a cycle with win_cnt==255:
    - util_i <= gcnt_i + (req_ack_i this cycle), saturated to 255.
    - gcnt_i <= 0.
  - util_i holds its value between window ends.
- Simultaneous events: a grant on the same cycle the link accepts the held word is legal and is the normal streaming case.
- Invariants:
  - No packet is duplicated or lost.
  - Packets from a given source leave in the order that source presents them.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with all valids low → tx_valid=0, tx_data=0, util_*=0, req_ack_*=0 for 10 cycles.
- Priority: tx_ready=1; sources 0/1/2 hold priorities 0x10/0x80/0x40 → grant order 1,2,0. Each packet appears on tx_data exactly 1 cycle after its ack, with MSB=1.
- Round-robin: all three valid at equal priority 0x20, tx_ready=1, rr_ptr=0 after reset → acks cycle 1,2,0,1,2,0…; no source ever acked on two consecutive cycles.
- Backpressure: tx_ready=0 for 5 cycles with a word held → tx_data/tx_valid stable, no req_ack. Raise tx_ready → the held word is accepted and the next grant occurs in that same cycle.
- Starvation: source 0 at priority 0xFF continuously; source 2 at 0x01 continuously; tx_ready=1 → source 2 acked once every 33 cycles (32 waits, then forced), source 0 on all other cycles.
- Utilisation: source 0 alone valid every cycle for 512 cycles, tx_ready=1 → util_0=255 (saturated) after the first window end, util_1=util_2=0. With valid on alternate cycles → util_0=128.
